alm_config_loader: RTL and testbench
====================================

// Module: alm_config_loader
// PURPOSE
//  Serial configuration controller for a chain of ALM tiles: takes bitstream words over a
//  valid/ready stream and shifts them LSB-first into the daisy-chained config_in/config_en
//  path, where config_out of each tile feeds config_in of the next.
//  Simultaneously captures the bits leaving the chain tail and returns them as words, so the
//  previous configuration is read back during every load.
//  Sits between the host/bitstream source and the head/tail of the ALM config chain.
// PARAMETERS
//  WORD_W     8..64, default 32  : width of bitstream and readback words
//  CHAIN_LEN  >=1, default 1024  : total config bits in the chain (sum over all tiles)
//  CNT_W      default $clog2(CHAIN_LEN+1) : bit-counter width (derived, do not override)
// PORTS
//  clk           in   1       : single clock; the chain's config_clk is tied to this clk
//  clear_sync_n  in   1       : synchronous active-low reset, sampled on posedge clk
//  start         in   1       : begin a load session (honoured only in IDLE)
//  abort         in   1       : terminate the session at once; sets err
//  s_data        in   WORD_W  : bitstream word, bit 0 is shifted first
//  s_valid       in   1       : s_data valid
//  s_ready       out  1       : loader accepts s_data this cycle
//  cfg_in        out  1       : to config_in of the head tile
//  cfg_en        out  1       : to config_en of all tiles; chain shifts on clk edges while 1
//  cfg_out       in   1       : from config_out of the tail tile
//  rb_data       out  WORD_W  : readback word, bit 0 = first bit out of the chain
//  rb_valid      out  1       : 1-cycle pulse, rb_data valid; there is no backpressure
//  busy          out  1       : 1 in every state except IDLE
//  done          out  1       : 1-cycle pulse when CHAIN_LEN bits have been shifted
//  err           out  1       : sticky abort flag; cleared by an accepted start or reset
// BEHAVIOUR
//  Reset: state=IDLE. s_ready, cfg_en, cfg_in, rb_valid, busy, done and err are 0. rb_data=0.
//    Bit and word counters are 0.
//  States: IDLE -> WAIT_WORD -> SHIFT -> (WAIT_WORD | DONE) -> IDLE.
//  IDLE: on start & ~abort, clear err, bitcnt, rb counter and rb shift register; go to
//    WAIT_WORD. A start outside IDLE is ignored.
//  WAIT_WORD: s_ready=1, combinational from state. On s_valid&s_ready, latch s_data into
//    shreg, set wbit=0 and go to SHIFT.
//  SHIFT: one bit per cycle. cfg_en=(state==SHIFT)&~abort and cfg_in=shreg[0] are
//    combinational. s_ready=0.
//    - On each shifting edge: shreg>>=1, wbit++, bitcnt++.
//    - cfg_out is sampled in the same cycle (it is the tail bit before the edge) into the
//      rb shift register at position rbcnt.
//    - Leave SHIFT after the edge where bitcnt reaches CHAIN_LEN (go to DONE) or wbit
//      reaches WORD_W (go to WAIT_WORD).
//    - Result: a word costs WORD_W+1 cycles (1 accept cycle plus WORD_W shift cycles).
//  Final partial word: if CHAIN_LEN%WORD_W!=0, the last word shifts only CHAIN_LEN%WORD_W
//    bits and its remaining high bits are discarded. No extra words are accepted after that.
//  Readback: rb_valid is registered and pulses the cycle after the WORD_W-th bit is
//    captured. At session end, a partial rb word is emitted with its high bits zero. Total
//    rb pulses per session = ceil(CHAIN_LEN/WORD_W).
//  DONE: done=1 for exactly 1 cycle, then IDLE. busy stays 1 during DONE.
//  Abort:
//    - In WAIT_WORD, SHIFT or DONE: next state is IDLE and err<=1.
//    - A word offered in the abort cycle is not accepted (s_ready is gated by ~abort).
//    - A partial rb word is dropped (no rb_valid). No done pulse is produced.
//    - The chain is left partially shifted; the host must reload.
//    - abort in IDLE has no effect.
//  clear_sync_n low mid-session: identical to reset and takes priority over everything.
//    cfg_en is 0 from the next cycle. err is not set.
//  Counters never wrap: bitcnt is bounded by CHAIN_LEN and wbit by WORD_W.
// TESTING  (bench params WORD_W=8, CHAIN_LEN=20, behavioural 20-bit chain model)
//  1 Reset: hold clear_sync_n=0 for 3 cycles -> all outputs 0 and s_ready=0 (IDLE).
//  2 Full load: chain preloaded with 20'hABCDE; start, then words 8'h5A, 8'hC3, 8'h0F with
//    s_valid always high.
//    -> exactly 20 cfg_en cycles; chain ends at 20'hFC35A.
//    -> rb_data = 8'hDE, 8'hBC, 8'h0A; three rb_valid pulses.
//    -> done pulse at cycle 3*1+20+1 after start; s_ready never high after the 3rd accept.
//  3 Stalled source: s_valid drops for 5 cycles between words
//    -> cfg_en stays 0 and s_ready stays 1 during the gap; final chain contents match case 2.
//  4 Abort in SHIFT: assert abort on the 4th bit of word 2 (12 edges done)
//    -> cfg_en=0 in that cycle and no further shifts; err=1, busy=0, no done pulse.
//    -> next start clears err.
//  5 start while busy, and start&abort together in IDLE -> both ignored; state is unchanged.
//  6 Reset mid-SHIFT (clear_sync_n=0 after 9 bits) -> IDLE next cycle, err=0, no rb_valid
//    and no done pulse.

Source files
------------

// File: rtl/alm_config_loader.sv
// alm_config_loader: streams bitstream words LSB-first into an ALM config chain while reading back the previous contents
module alm_config_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              clear_sync_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_in,
  output logic              cfg_en,
  input  logic              cfg_out,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int WW = $clog2(WORD_W + 1);
  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WORD_W-1:0] shreg, rbsh, rb_nx;
  logic [WW-1:0] wbit;
  logic [CNT_W-1:0] bitcnt;
  logic shift, last_bit, word_end, go;
  always_comb begin
    go       = state == IDLE && start && !abort;
    shift    = state == SHIFT && !abort;
    last_bit = bitcnt == CNT_W'(CHAIN_LEN - 1);
    word_end = wbit == WW'(WORD_W - 1);
    rb_nx    = rbsh | (WORD_W'(cfg_out) << wbit);
    s_ready  = state == WAIT_WORD && !abort;
    cfg_en   = shift;
    cfg_in   = shreg[0];
    busy     = state != IDLE;
    done     = state == DONE && !abort;
    state_nx = state == IDLE      ? (go ? WAIT_WORD : IDLE) :
               abort              ? IDLE :
               state == WAIT_WORD ? (s_valid ? SHIFT : WAIT_WORD) :
               state == SHIFT     ? (last_bit ? DONE : word_end ? WAIT_WORD : SHIFT) :
                                    IDLE;
  end
  always_ff @(posedge clk) begin
    if (!clear_sync_n) begin
      state    <= IDLE;
      shreg    <= '0;
      rbsh     <= '0;
      wbit     <= '0;
      bitcnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      rb_valid <= 1'b0;
      if (go) begin
        err    <= 1'b0;
        bitcnt <= '0;
        wbit   <= '0;
        rbsh   <= '0;
      end
      if (busy && abort)
        err <= 1'b1;
      if (s_ready && s_valid) begin
        shreg <= s_data;
        wbit  <= '0;
      end
      if (shift) begin
        shreg  <= shreg >> 1;
        wbit   <= wbit + 1'b1;
        bitcnt <= bitcnt + 1'b1;
        rbsh   <= (word_end || last_bit) ? '0 : rb_nx;
        if (word_end || last_bit) begin
          rb_data  <= rb_nx;
          rb_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alm_config_loader.sv
// tb_alm_config_loader: directed checks of alm_config_loader against a 20-bit behavioural chain
module tb_alm_config_loader;
  logic clk = 1'b0;
  logic clear_sync_n, start, abort, s_valid, s_ready, cfg_in, cfg_en, cfg_out, rb_valid, busy, done, err;
  logic [7:0] s_data, rb_data;
  logic [19:0] chain, ld_val;
  logic ld = 1'b0;
  int n_assert = 0, n_fail = 0;
  int cyc = 0, en_cnt = 0, rb_cnt = 0, done_cnt = 0, acc_cnt = 0, done_cyc = 0, start_cyc = 0;
  logic [7:0] rb_mem [64];

  alm_config_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .clk(clk), .clear_sync_n(clear_sync_n), .start(start), .abort(abort),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(cfg_out),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ld) chain <= ld_val;
    else if (cfg_en) chain <= {cfg_in, chain[19:1]};
  assign cfg_out = chain[0];

  always @(negedge clk) begin
    cyc++;
    if (cfg_en) en_cnt++;
    if (rb_valid && rb_cnt < 64) begin
      rb_mem[rb_cnt] = rb_data;
      rb_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_ready && s_valid) acc_cnt++;
    if (start && !busy && !abort && clear_sync_n) start_cyc = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] v);
    ld_val = v;
    ld = 1'b1;
    step();
    ld = 1'b0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset;
    clear_sync_n = 1'b0;
    step();
    clear_sync_n = 1'b1;
  endtask

  task automatic feed(input logic [23:0] ws, input int gap, output int gcnt);
    int k = 0;
    int guard = 0;
    gcnt = 0;
    s_valid = 1'b1;
    s_data = ws[7:0];
    while (k < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (s_ready && s_valid) k++;
      else if (s_ready && !s_valid) begin
        gcnt++;
        n_assert++;
        if (cfg_en !== 1'b0) begin
          n_fail++;
          $display("FAIL gap_cfg_en: got %b want 0", cfg_en);
        end
      end else if (k == 1 && !s_valid && gcnt > 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL gap_s_ready: got %b want 1", s_ready);
      end
      step();
      s_data = (k < 3) ? ws[k*8 +: 8] : 8'hFF;
      s_valid = !(k == 1 && gap > 0 && gcnt < gap);
    end
    n_assert++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d want 3", k);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 80 && done_cnt == d0; i++) step();
  endtask

  task automatic test_reset;
    clear_sync_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    s_valid = 1'b1;
    s_data = 8'hFF;
    repeat (3) step();
    @(negedge clk);
    n_assert++;
    if ({s_ready, cfg_en, cfg_in, rb_valid, busy, done, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0000000", {s_ready, cfg_en, cfg_in, rb_valid, busy, done, err});
    end
    n_assert++;
    if (rb_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rb_data: got %h want 00", rb_data);
    end
    start = 1'b0;
    s_valid = 1'b0;
    clear_sync_n = 1'b1;
    step();
    @(negedge clk);
    n_assert++;
    if ({busy, s_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: busy,s_ready got %b want 00", {busy, s_ready});
    end
  endtask

  task automatic run_load(input string name, input int gap);
    int e0, r0, d0, a0, gc;
    preload(20'hABCDE);
    e0 = en_cnt; r0 = rb_cnt; d0 = done_cnt; a0 = acc_cnt;
    s_valid = 1'b1;
    s_data = 8'h5A;
    pulse_start();
    feed(24'h0FC35A, gap, gc);
    wait_done(d0);
    repeat (2) step();
    n_assert++;
    if (en_cnt - e0 != 20) begin
      n_fail++;
      $display("FAIL %s_shift_count: got %0d want 20", name, en_cnt - e0);
    end
    n_assert++;
    if (chain !== 20'hFC35A) begin
      n_fail++;
      $display("FAIL %s_chain: got %h want fc35a", name, chain);
    end
    n_assert++;
    if (rb_cnt - r0 != 3) begin
      n_fail++;
      $display("FAIL %s_rb_pulses: got %0d want 3", name, rb_cnt - r0);
    end else begin
      n_assert++;
      if ({rb_mem[r0], rb_mem[r0+1], rb_mem[r0+2]} !== 24'hDEBC0A) begin
        n_fail++;
        $display("FAIL %s_rb_words: got %h %h %h want de bc 0a", name, rb_mem[r0], rb_mem[r0+1], rb_mem[r0+2]);
      end
    end
    n_assert++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_done_pulses: got %0d want 1", name, done_cnt - d0);
    end
    n_assert++;
    if (acc_cnt - a0 != 3) begin
      n_fail++;
      $display("FAIL %s_accepts: got %0d want 3", name, acc_cnt - a0);
    end
    if (gap == 0) begin
      n_assert++;
      if (done_cyc - start_cyc != 24) begin
        n_fail++;
        $display("FAIL %s_done_latency: got %0d want 24", name, done_cyc - start_cyc);
      end
    end else begin
      n_assert++;
      if (gc != gap) begin
        n_fail++;
        $display("FAIL %s_gap_len: got %0d want %0d", name, gc, gap);
      end
    end
    n_assert++;
    if ({busy, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_end_state: busy,err got %b want 00", name, {busy, err});
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full_load;
    run_load("full", 0);
  endtask

  task automatic test_stalled_source;
    run_load("stall", 5);
  endtask

  task automatic test_abort_shift;
    int e0, r0, d0, a0;
    preload(20'hABCDE);
    e0 = en_cnt; r0 = rb_cnt; d0 = done_cnt; a0 = acc_cnt;
    s_valid = 1'b1;
    s_data = 8'h5A;
    pulse_start();
    for (int i = 0; i < 100 && en_cnt - e0 != 12; i++) begin
      s_data = (acc_cnt == a0) ? 8'h5A : 8'hC3;
      step();
    end
    abort = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({cfg_en, s_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_gate: cfg_en,s_ready got %b want 00", {cfg_en, s_ready});
    end
    step();
    abort = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({err, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_flags: err,busy got %b want 10", {err, busy});
    end
    repeat (3) step();
    n_assert++;
    if (en_cnt - e0 != 12 || chain !== 20'h35AAB) begin
      n_fail++;
      $display("FAIL abort_chain: shifts %0d chain %h want 12 35aab", en_cnt - e0, chain);
    end
    n_assert++;
    if (done_cnt != d0 || rb_cnt - r0 != 1 || rb_mem[r0] !== 8'hDE) begin
      n_fail++;
      $display("FAIL abort_outputs: done %0d rb %0d first %h want 0 1 de", done_cnt - d0, rb_cnt - r0, rb_mem[r0]);
    end
    pulse_start();
    @(negedge clk);
    n_assert++;
    if ({err, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_restart: err,busy got %b want 01", {err, busy});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_start_ignored;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({busy, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL start_abort_idle: busy,err got %b want 01", {busy, err});
    end
    pulse_start();
    pulse_start();
    @(negedge clk);
    n_assert++;
    if ({busy, s_ready, err, cfg_en} !== 4'b1100) begin
      n_fail++;
      $display("FAIL start_while_busy: busy,s_ready,err,cfg_en got %b want 1100", {busy, s_ready, err, cfg_en});
    end
    do_reset();
  endtask

  task automatic test_reset_mid_shift;
    int e0, r0, d0, a0;
    preload(20'hABCDE);
    e0 = en_cnt; a0 = acc_cnt;
    s_valid = 1'b1;
    s_data = 8'h5A;
    pulse_start();
    for (int i = 0; i < 100 && en_cnt - e0 != 9; i++) begin
      s_data = (acc_cnt == a0) ? 8'h5A : 8'hC3;
      step();
    end
    clear_sync_n = 1'b0;
    step();
    clear_sync_n = 1'b1;
    r0 = rb_cnt; d0 = done_cnt;
    @(negedge clk);
    n_assert++;
    if ({busy, err, cfg_en, s_ready, rb_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: busy,err,cfg_en,s_ready,rb_valid got %b want 00000", {busy, err, cfg_en, s_ready, rb_valid});
    end
    repeat (5) step();
    n_assert++;
    if (rb_cnt != r0 || done_cnt != d0) begin
      n_fail++;
      $display("FAIL reset_mid_pulses: rb %0d done %0d want 0 0", rb_cnt - r0, done_cnt - d0);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    clear_sync_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    test_reset();
    test_full_load();
    test_stalled_source();
    test_abort_shift();
    test_start_ignored();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
